// File: rtl/bcd_counter_pkg.sv
// Shared types and helpers for the BCD up/down counter.
// Digit type, digit limits, BCD conversion and validation.
package bcd_counter_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_DIGIT_MAX = 4'd9;
  localparam bcd_digit_t BCD_DIGIT_MIN = 4'd0;
  localparam int BCD_MAX_DIGITS = 8;

  function automatic logic [31:0] to_bcd(
    input int value,
    input int digits
  );
    logic [31:0] r;
    int v;
    r = '0;
    v = value;
    for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
      if (i < digits) begin
        r[4*i+:4] = 4'(v % 10);
        v = v / 10;
      end
    end
    return r;
  endfunction

  function automatic logic bcd_is_valid(
    input logic [31:0] vec,
    input int digits
  );
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
      if (i < digits && vec[4*i+:4] > BCD_DIGIT_MAX)
        ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit of the up/down ripple chain (combinational).
// Ports: digit, up_down, step_in (carry/borrow in) -> digit_nxt, step_out.
module bcd_digit_step
  import bcd_counter_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       up_down,
  input  logic       step_in,
  output logic [3:0] digit_nxt,
  output logic       step_out
);

  always_comb begin
    digit_nxt = digit;
    step_out  = 1'b0;
    if (step_in) begin
      if (up_down) begin
        if (digit >= BCD_DIGIT_MAX) begin
          digit_nxt = BCD_DIGIT_MIN;
          step_out  = 1'b1;
        end else begin
          digit_nxt = digit + 4'd1;
        end
      end else begin
        if (digit == BCD_DIGIT_MIN) begin
          digit_nxt = BCD_DIGIT_MAX;
          step_out  = 1'b1;
        end else begin
          digit_nxt = digit - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter, range 0..MAX_VALUE, load + pulses.
// Ports: clk, rst, en, up_down, load, load_val -> count, wrap,
// at_limit, load_err. Macro BCD_UPDOWN_COUNTER_SATURATE_EN: saturate.
module bcd_updown_counter
  import bcd_counter_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int MAX_VALUE  = 99
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up_down,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    wrap,
  output logic                    at_limit,
  output logic                    load_err
);

  localparam int W = 4 * NUM_DIGITS;
  localparam logic [31:0] MAX_BCD32 =
    to_bcd(MAX_VALUE, NUM_DIGITS);
  localparam logic [W-1:0] MAX_BCD = MAX_BCD32[W-1:0];

  if (NUM_DIGITS < 1 || NUM_DIGITS > BCD_MAX_DIGITS)
  begin : g_bad_digits
    $error("NUM_DIGITS must be 1..8");
  end

  if (MAX_VALUE < 1 ||
      MAX_VALUE > (10 ** NUM_DIGITS) - 1)
  begin : g_bad_max
    $error("MAX_VALUE out of range for NUM_DIGITS");
  end

  logic [W-1:0]        count_q;
  logic [W-1:0]        count_d;
  logic [W-1:0]        step_nxt;
  logic [NUM_DIGITS:0] chain;
  logic                err_q;
  logic                err_d;
  logic                wrap_d;
  logic                hit_limit;
  logic                roll;
  logic                load_ok;

  assign chain[0] = 1'b1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit_step u_step (
      .digit     (count_q[4*g+:4]),
      .up_down   (up_down),
      .step_in   (chain[g]),
      .digit_nxt (step_nxt[4*g+:4]),
      .step_out  (chain[g+1])
    );
  end

  assign hit_limit = up_down ? (count_q == MAX_BCD)
                             : (count_q == '0);

  // A ripple out of the top digit can only coincide with
  // the limit, but treat it as a roll so it never escapes.
  assign roll = hit_limit | chain[NUM_DIGITS];

  // With every digit legal, BCD order equals binary order.
  assign load_ok = bcd_is_valid(32'(load_val), NUM_DIGITS)
                && (load_val <= MAX_BCD);

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (load) begin
      if (load_ok) count_d = load_val;
      else         err_d   = 1'b1;
    end else if (en) begin
      if (roll) begin
`ifdef BCD_UPDOWN_COUNTER_SATURATE_EN
        count_d = count_q;
`else
        count_d = up_down ? '0 : MAX_BCD;
        wrap_d  = 1'b1;
`endif
      end else begin
        count_d = step_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

`ifdef BCD_UPDOWN_COUNTER_SATURATE_EN
  logic unused_wrap;
  assign unused_wrap = wrap_d;
  assign wrap = 1'b0;
`else
  logic wrap_q;
  always_ff @(posedge clk) begin
    if (rst) wrap_q <= 1'b0;
    else     wrap_q <= wrap_d;
  end
  assign wrap = wrap_q;
`endif

  assign count    = count_q;
  assign load_err = err_q;
  assign at_limit = hit_limit;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench: 2-digit/59 and 3-digit/999 counters
// against an integer model plus directed literal checks.
module tb_bcd_updown_counter;

`ifdef BCD_UPDOWN_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] n;
    logic        w;
    logic        e;
  } mres_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst = 1'b1, a_en = 1'b0, a_ud = 1'b1;
  logic        a_ld = 1'b0;
  logic [7:0]  a_lv = '0;
  logic [7:0]  a_count;
  logic        a_wrap, a_at, a_err;

  logic        b_rst = 1'b1, b_en = 1'b0, b_ud = 1'b1;
  logic        b_ld = 1'b0;
  logic [11:0] b_lv = '0;
  logic [11:0] b_count;
  logic        b_wrap, b_at, b_err;

  int checks = 0;
  int errors = 0;
  int wcnt   = 0;
  bit armed  = 1'b0;
  mres_t ma = '0;
  mres_t mb = '0;

  bcd_updown_counter #(.NUM_DIGITS(2), .MAX_VALUE(59)) u_a (
    .clk(clk), .rst(a_rst), .en(a_en), .up_down(a_ud),
    .load(a_ld), .load_val(a_lv), .count(a_count),
    .wrap(a_wrap), .at_limit(a_at), .load_err(a_err)
  );

  bcd_updown_counter #(.NUM_DIGITS(3), .MAX_VALUE(999)) u_b (
    .clk(clk), .rst(b_rst), .en(b_en), .up_down(b_ud),
    .load(b_ld), .load_val(b_lv), .count(b_count),
    .wrap(b_wrap), .at_limit(b_at), .load_err(b_err)
  );

  function automatic logic [31:0] int2bcd(input int v);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i+:4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic mres_t mstep(
    input int cur, input bit r, input bit ld,
    input logic [31:0] lv, input int nd, input int mx,
    input bit en, input bit ud
  );
    mres_t o;
    bit ok;
    int val, pw, d;
    o.n = cur;
    o.w = 1'b0;
    o.e = 1'b0;
    if (r) begin
      o.n = 0;
    end else if (ld) begin
      ok = 1'b1;
      val = 0;
      pw = 1;
      for (int i = 0; i < nd; i++) begin
        d = int'(lv[4*i+:4]);
        if (d > 9) ok = 1'b0;
        val += d * pw;
        pw *= 10;
      end
      if (ok && val <= mx) o.n = val;
      else o.e = 1'b1;
    end else if (en) begin
      if (ud) begin
        if (cur == mx) begin
          o.n = SAT ? mx : 0;
          o.w = !SAT;
        end else o.n = cur + 1;
      end else begin
        if (cur == 0) begin
          o.n = SAT ? 0 : mx;
          o.w = !SAT;
        end else o.n = cur - 1;
      end
    end
    return o;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp,
               $time);
    end
  endtask

  always @(posedge clk) begin
    ma <= mstep(int'(ma.n), a_rst, a_ld, 32'(a_lv), 2, 59,
                a_en, a_ud);
    mb <= mstep(int'(mb.n), b_rst, b_ld, 32'(b_lv), 3, 999,
                b_en, b_ud);
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("a_count", 32'(a_count), int2bcd(int'(ma.n)));
      chk("a_wrap", 32'(a_wrap), 32'(ma.w));
      chk("a_err", 32'(a_err), 32'(ma.e));
      chk("a_at_limit", 32'(a_at),
          32'(a_ud ? (ma.n == 59) : (ma.n == 0)));
      chk("b_count", 32'(b_count), int2bcd(int'(mb.n)));
      chk("b_wrap", 32'(b_wrap), 32'(mb.w));
      chk("b_err", 32'(b_err), 32'(mb.e));
      chk("b_at_limit", 32'(b_at),
          32'(b_ud ? (mb.n == 999) : (mb.n == 0)));
      if (a_wrap) wcnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ad(input bit r, input bit ld,
                    input logic [7:0] lv,
                    input bit en, input bit ud);
    a_rst = r; a_ld = ld; a_lv = lv; a_en = en; a_ud = ud;
  endtask

  task automatic bd(input bit r, input bit ld,
                    input logic [11:0] lv,
                    input bit en, input bit ud);
    b_rst = r; b_ld = ld; b_lv = lv; b_en = en; b_ud = ud;
  endtask

  initial begin
    ad(1, 0, 8'h00, 0, 1);
    bd(1, 0, 12'h000, 0, 1);
    tick();
    armed = 1'b1;
    tick();
    chk("rst_count", 32'(a_count), 32'h00);
    chk("rst_wrap", 32'(a_wrap), 32'h0);
    chk("rst_err", 32'(a_err), 32'h0);

    wcnt = 0;
    for (int i = 0; i < 60; i++) begin
      ad(0, 0, 8'h00, 1, 1);
      tick();
      if (i == 8) chk("up_09", 32'(a_count), 32'h09);
      if (i == 9) chk("up_10", 32'(a_count), 32'h10);
      if (i == 58) begin
        chk("up_59", 32'(a_count), 32'h59);
        chk("model_59", ma.n, 32'd59);
        chk("at_59", 32'(a_at), 32'h1);
      end
      if (i == 59) begin
        chk("up_wrap_cnt", 32'(a_count), SAT ? 32'h59 : 32'h00);
        chk("up_wrap", 32'(a_wrap), SAT ? 32'h0 : 32'h1);
      end
    end
    ad(0, 0, 8'h00, 0, 1);
    tick();
    chk("up_wrap_pulses", 32'(wcnt), SAT ? 32'd0 : 32'd1);

    ad(0, 1, 8'h30, 0, 0);
    tick();
    chk("load_30", 32'(a_count), 32'h30);
    wcnt = 0;
    for (int i = 0; i < 31; i++) begin
      ad(0, 0, 8'h00, 1, 0);
      tick();
      if (i == 19) chk("dn_10", 32'(a_count), 32'h10);
      if (i == 20) chk("dn_09", 32'(a_count), 32'h09);
      if (i == 29) chk("dn_00", 32'(a_count), 32'h00);
      if (i == 30) begin
        chk("dn_wrap_cnt", 32'(a_count), SAT ? 32'h00 : 32'h59);
        chk("model_dn", ma.n, SAT ? 32'd0 : 32'd59);
      end
    end
    ad(0, 0, 8'h00, 0, 0);
    tick();
    chk("dn_wrap_pulses", 32'(wcnt), SAT ? 32'd0 : 32'd1);

    ad(0, 1, 8'h1A, 0, 0);
    tick();
    chk("bad_digit_err", 32'(a_err), 32'h1);
    chk("bad_digit_hold", 32'(a_count), SAT ? 32'h00 : 32'h59);
    ad(0, 1, 8'h75, 0, 0);
    tick();
    chk("over_max_err", 32'(a_err), 32'h1);
    chk("over_max_hold", 32'(a_count), SAT ? 32'h00 : 32'h59);
    ad(0, 1, 8'h42, 0, 0);
    tick();
    chk("load_42", 32'(a_count), 32'h42);
    chk("load_42_err", 32'(a_err), 32'h0);

    ad(0, 1, 8'h05, 1, 1);
    tick();
    chk("load_pri", 32'(a_count), 32'h05);
    chk("load_pri_wrap", 32'(a_wrap), 32'h0);
    ad(0, 1, 8'h36, 0, 1);
    tick();
    ad(0, 0, 8'h00, 1, 1);
    tick();
    chk("cnt_37", 32'(a_count), 32'h37);
    ad(1, 0, 8'h00, 1, 1);
    tick();
    chk("rst_mid", 32'(a_count), 32'h00);
    ad(1, 1, 8'hAA, 0, 0);
    tick();
    chk("rst_sup_err", 32'(a_err), 32'h0);

    ad(0, 0, 8'h00, 0, 0);
    tick();
    chk("at_dn_idle", 32'(a_at), 32'h1);
    ad(0, 0, 8'h00, 0, 1);
    #1;
    chk("at_up_idle", 32'(a_at), 32'h0);
    tick();

    ad(0, 1, 8'h59, 0, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      ad(0, 0, 8'h00, 1, 1);
      tick();
      if (i == 0) chk("sat_up_w", 32'(a_wrap), SAT ? 32'h0 : 32'h1);
    end
    chk("sat_up", 32'(a_count), SAT ? 32'h59 : 32'h02);
    ad(0, 1, 8'h00, 0, 0);
    tick();
    ad(0, 0, 8'h00, 1, 0);
    tick();
    chk("sat_dn", 32'(a_count), SAT ? 32'h00 : 32'h59);
    ad(0, 0, 8'h00, 0, 1);

    bd(0, 1, 12'h099, 0, 1);
    tick();
    bd(0, 0, 12'h000, 1, 1);
    tick();
    chk("b_100", 32'(b_count), 32'h100);
    bd(0, 0, 12'h000, 1, 0);
    tick();
    chk("b_099", 32'(b_count), 32'h099);
    bd(0, 1, 12'h9A0, 0, 1);
    tick();
    chk("b_bad_err", 32'(b_err), 32'h1);
    bd(0, 1, 12'h999, 0, 1);
    tick();
    bd(0, 0, 12'h000, 1, 1);
    tick();
    chk("b_wrap_cnt", 32'(b_count), SAT ? 32'h999 : 32'h000);
    chk("b_wrap", 32'(b_wrap), SAT ? 32'h0 : 32'h1);
    bd(0, 0, 12'h000, 0, 1);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
